// File: rtl/seg_display_pkg.sv
// seg_display_pkg: display modes, FSM states, active-low glyphs and nibble decoder
package seg_display_pkg;
    typedef enum logic [1:0] {MODE_HEX = 2'b00, MODE_UDEC = 2'b01, MODE_SDEC = 2'b10} mode_t;
    typedef enum logic [1:0] {ST_IDLE, ST_CONV_A, ST_CONV_B, ST_COMMIT} state_t;
    localparam logic [7:0] GLYPH_0 = 8'hC0, GLYPH_1 = 8'hF9, GLYPH_2 = 8'hA4, GLYPH_3 = 8'hB0;
    localparam logic [7:0] GLYPH_4 = 8'h99, GLYPH_5 = 8'h92, GLYPH_6 = 8'h82, GLYPH_7 = 8'hF8;
    localparam logic [7:0] GLYPH_8 = 8'h80, GLYPH_9 = 8'h90, GLYPH_A = 8'h88, GLYPH_B = 8'h83;
    localparam logic [7:0] GLYPH_C = 8'hC6, GLYPH_D = 8'hA1, GLYPH_E = 8'h86, GLYPH_F = 8'h8E;
    localparam logic [7:0] GLYPH_BLANK = 8'hFF, GLYPH_MINUS = 8'hBF;
    function automatic logic [7:0] nib_glyph(input logic [3:0] n);
        case (n)
            4'h0: return GLYPH_0;
            4'h1: return GLYPH_1;
            4'h2: return GLYPH_2;
            4'h3: return GLYPH_3;
            4'h4: return GLYPH_4;
            4'h5: return GLYPH_5;
            4'h6: return GLYPH_6;
            4'h7: return GLYPH_7;
            4'h8: return GLYPH_8;
            4'h9: return GLYPH_9;
            4'hA: return GLYPH_A;
            4'hB: return GLYPH_B;
            4'hC: return GLYPH_C;
            4'hD: return GLYPH_D;
            4'hE: return GLYPH_E;
            default: return GLYPH_F;
        endcase
    endfunction
endpackage

// File: rtl/seg_scan_display_if.sv
// seg_scan_display_if: processor-side load/busy bus of the display engine
interface seg_scan_display_if #(parameter int NUM_DIGITS = 8, parameter int VAL_W = 16);
    logic [VAL_W-1:0] val_a;
    logic [VAL_W-1:0] val_b;
    logic [NUM_DIGITS-1:0] dp_mask;
    logic [1:0] mode;
    logic load;
    logic busy;
    logic ovf;
    modport master (output val_a, val_b, dp_mask, mode, load, input busy, ovf);
    modport slave (input val_a, val_b, dp_mask, mode, load, output busy, ovf);
endinterface

// File: rtl/bin2bcd_seq.sv
// bin2bcd_seq: VAL_W-cycle double dabble; the first shift happens on the start edge
module bin2bcd_seq #(
    parameter int VAL_W = 16,
    parameter int DIGITS = 5
) (
    input  logic                  i_clk,
    input  logic                  i_rst,
    input  logic                  i_start,
    input  logic [VAL_W-1:0]      i_val,
    output logic                  o_done,
    output logic [4*DIGITS-1:0]   o_bcd
);
    localparam int CW = $clog2(VAL_W + 1);
    logic [VAL_W-1:0] r_sh;
    logic [CW-1:0] r_cnt;
    logic [4*DIGITS-1:0] r_bcd;
    function automatic logic [4*DIGITS-1:0] step(input logic [4*DIGITS-1:0] b, input logic in);
        logic [4*DIGITS-1:0] t;
        t = b;
        for (int k = 0; k < DIGITS; k++)
            t[4*k+:4] = t[4*k+:4] >= 4'd5 ? t[4*k+:4] + 4'd3 : t[4*k+:4];
        return {t[4*DIGITS-2:0], in};
    endfunction
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_sh <= '0;
            r_cnt <= '0;
            r_bcd <= '0;
        end else if (i_start) begin
            r_bcd <= step('0, i_val[VAL_W-1]);
            r_sh <= i_val << 1;
            r_cnt <= CW'(VAL_W - 1);
        end else if (r_cnt != '0) begin
            r_bcd <= step(r_bcd, r_sh[VAL_W-1]);
            r_sh <= r_sh << 1;
            r_cnt <= r_cnt - 1'b1;
        end
    end
    assign o_done = r_cnt == '0;
    assign o_bcd = r_bcd;
endmodule

// File: rtl/seg_scan_display.sv
// seg_scan_display: multiplexed 7-seg engine (hex/udec/sdec); SEG_LEADING_ZERO_BLANK_EN blanks leading zeros
module seg_scan_display import seg_display_pkg::*; #(
    parameter int NUM_DIGITS = 8,
    parameter int VAL_W = 16,
    parameter int SCAN_DIV = 1024
) (
    input  logic                  i_clk,
    input  logic                  i_rst,
    seg_scan_display_if.slave     bus,
    output logic [7:0]            o_seg,
    output logic [NUM_DIGITS-1:0] o_seg_sel
);
    localparam int H = NUM_DIGITS / 2;
    localparam int BD = VAL_W * 30103 / 100000 + 1;
    localparam int HD = (VAL_W + 3) / 4;
    localparam int NS0 = BD > HD ? BD : HD;
    localparam int NS = NS0 > H ? NS0 : H;
    localparam int IW = $clog2(NUM_DIGITS);
    localparam int CW = SCAN_DIV > 1 ? $clog2(SCAN_DIV) : 1;
    typedef struct packed {logic ovf; logic [8*H-1:0] g;} half_t;
    function automatic logic [VAL_W-1:0] mag(input logic [VAL_W-1:0] v, input logic [1:0] m);
        return (m == MODE_SDEC && v[VAL_W-1]) ? -v : v;
    endfunction
    // Digits at or above nd are not available to the magnitude; any nonzero one there overflows
    function automatic half_t render(input logic [VAL_W-1:0] v, input logic [4*BD-1:0] bcd, input logic [1:0] m);
        half_t r;
        logic [4*NS-1:0] s;
        logic neg;
        int nd;
`ifdef SEG_LEADING_ZERO_BLANK_EN
        logic lead;
        lead = 1'b1;
`endif
        neg = m == MODE_SDEC && v[VAL_W-1];
        nd = neg ? H - 1 : H;
        s = (m == MODE_UDEC || m == MODE_SDEC) ? (4*NS)'(bcd) : (4*NS)'(v);
        r.ovf = 1'b0;
        for (int k = 0; k < NS; k++)
            if (k >= nd && s[4*k+:4] != 4'd0) r.ovf = 1'b1;
        for (int k = 0; k < H; k++)
            r.g[8*k+:8] = k < nd ? nib_glyph(s[4*k+:4]) : GLYPH_MINUS;
`ifdef SEG_LEADING_ZERO_BLANK_EN
        for (int k = H - 1; k > 0; k--)
            if (k < nd) begin
                if (lead && s[4*k+:4] == 4'd0) r.g[8*k+:8] = GLYPH_BLANK;
                else lead = 1'b0;
            end
`endif
        if (r.ovf) r.g = {H{GLYPH_MINUS}};
        return r;
    endfunction
    state_t r_state;
    logic r_busy, r_ovf;
    logic [VAL_W-1:0] r_val_a, r_val_b;
    logic [1:0] r_mode;
    logic [NUM_DIGITS-1:0] r_dp_ld, r_dp;
    logic [4*BD-1:0] r_bcd_a;
    logic [8*NUM_DIGITS-1:0] r_buf;
    logic [CW-1:0] r_cnt;
    logic [IW-1:0] r_idx;
    logic w_acc, w_dec, w_start, w_done, w_commit;
    logic [VAL_W-1:0] w_conv_val;
    logic [4*BD-1:0] w_bcd;
    half_t w_a, w_b;
    logic [8*NUM_DIGITS-1:0] w_buf;
    logic [NUM_DIGITS-1:0] w_dp;
    assign w_acc = bus.load && r_state == ST_IDLE;
    assign w_dec = bus.mode == MODE_UDEC || bus.mode == MODE_SDEC;
    assign w_start = (w_acc && w_dec) || (r_state == ST_CONV_A && w_done);
    assign w_conv_val = r_state == ST_IDLE ? mag(bus.val_a, bus.mode) : mag(r_val_b, r_mode);
    // B's digits stay in the converter until COMMIT, so only A needs a copy
    assign w_a = render(r_val_a, r_bcd_a, r_mode);
    assign w_b = render(r_val_b, w_bcd, r_mode);
    assign w_commit = r_state == ST_COMMIT;
    assign w_buf = w_commit ? {w_b.g, w_a.g} : r_buf;
    assign w_dp = w_commit ? r_dp_ld : r_dp;
    assign bus.busy = r_busy;
    assign bus.ovf = r_ovf;
    bin2bcd_seq #(.VAL_W(VAL_W), .DIGITS(BD)) u_conv (
        .i_clk(i_clk), .i_rst(i_rst), .i_start(w_start), .i_val(w_conv_val),
        .o_done(w_done), .o_bcd(w_bcd)
    );
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_state <= ST_IDLE;
            r_busy <= 1'b0;
            r_ovf <= 1'b0;
            r_val_a <= '0;
            r_val_b <= '0;
            r_mode <= '0;
            r_dp_ld <= '0;
            r_dp <= '0;
            r_bcd_a <= '0;
            r_buf <= '1;
        end else begin
            case (r_state)
                ST_IDLE: if (w_acc) begin
                    r_val_a <= bus.val_a;
                    r_val_b <= bus.val_b;
                    r_mode <= bus.mode;
                    r_dp_ld <= bus.dp_mask;
                    r_busy <= 1'b1;
                    r_state <= w_dec ? ST_CONV_A : ST_COMMIT;
                end
                ST_CONV_A: if (w_done) begin
                    r_bcd_a <= w_bcd;
                    r_state <= ST_CONV_B;
                end
                ST_CONV_B: if (w_done) r_state <= ST_COMMIT;
                default: begin
                    r_buf <= w_buf;
                    r_dp <= w_dp;
                    r_ovf <= w_a.ovf | w_b.ovf;
                    r_busy <= 1'b0;
                    r_state <= ST_IDLE;
                end
            endcase
        end
    end
    // Scan reads the post-commit buffer so a new glyph shows the cycle after COMMIT
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_cnt <= '0;
            r_idx <= '0;
            o_seg <= 8'hFF;
            o_seg_sel <= '1;
        end else begin
            r_cnt <= r_cnt == CW'(SCAN_DIV - 1) ? '0 : r_cnt + 1'b1;
            if (r_cnt == CW'(SCAN_DIV - 1)) r_idx <= r_idx == IW'(NUM_DIGITS - 1) ? '0 : r_idx + 1'b1;
            o_seg <= w_buf[8*r_idx+:8] & ~{w_dp[r_idx], 7'd0};
            o_seg_sel <= ~(NUM_DIGITS'(1) << r_idx);
        end
    end
endmodule
